// File: rtl/ada_muldiv_div.sv
// Iterative radix-2 restoring divider (DIV/DIVU): one quotient bit per cycle plus a sign-fixup cycle.
// Optional macro ADA_DIV_ZERO_EN adds div_zero and a short-circuit path for a zero divisor.
module ada_muldiv_div #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  op_divs,
   input  logic                  op_divu,
   input  logic [DATA_WIDTH-1:0] dividend,
   input  logic [DATA_WIDTH-1:0] divisor,
   input  logic                  flush,
   output logic [DATA_WIDTH-1:0] quotient,
   output logic [DATA_WIDTH-1:0] remainder,
   output logic                  stall,
`ifdef ADA_DIV_ZERO_EN
   output logic                  div_zero,
`endif
   output logic                  done
);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} state_t;

   state_t                state_r;
   logic [CNT_WIDTH-1:0]  cnt_r;
   logic [DATA_WIDTH-1:0] rem_r;
   logic [DATA_WIDTH-1:0] quo_r;
   logic [DATA_WIDTH-1:0] dvs_r;
   logic                  neg_q_r;
   logic                  neg_r_r;
`ifdef ADA_DIV_ZERO_EN
   logic                  dz_r;
`endif

   logic                  start_s;
   logic                  dvd_neg_s;
   logic                  dvs_neg_s;
   logic [DATA_WIDTH-1:0] dvd_mag_s;
   logic [DATA_WIDTH-1:0] dvs_mag_s;
   logic [DATA_WIDTH:0]   shift_s;
   logic [DATA_WIDTH:0]   diff_s;

   function automatic logic [DATA_WIDTH-1:0] neg2c(input logic [DATA_WIDTH-1:0] v);
      return ~v + {{(DATA_WIDTH-1){1'b0}}, 1'b1};
   endfunction

   // Start qualification, operand magnitudes and the trial subtract
   always_comb begin
      start_s   = (op_divs | op_divu) & ~flush;
      dvd_neg_s = op_divs & dividend[DATA_WIDTH-1];
      dvs_neg_s = op_divs & divisor[DATA_WIDTH-1];
      dvd_mag_s = dvd_neg_s ? neg2c(dividend) : dividend;
      dvs_mag_s = dvs_neg_s ? neg2c(divisor) : divisor;
      shift_s   = {rem_r, quo_r[DATA_WIDTH-1]};
      diff_s    = shift_s - {1'b0, dvs_r};
   end

   // Divider FSM with registered results and handshake outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= IDLE;
         cnt_r     <= {CNT_WIDTH{1'b0}};
         rem_r     <= {DATA_WIDTH{1'b0}};
         quo_r     <= {DATA_WIDTH{1'b0}};
         dvs_r     <= {DATA_WIDTH{1'b0}};
         neg_q_r   <= 1'b0;
         neg_r_r   <= 1'b0;
         quotient  <= {DATA_WIDTH{1'b0}};
         remainder <= {DATA_WIDTH{1'b0}};
         stall     <= 1'b0;
         done      <= 1'b0;
`ifdef ADA_DIV_ZERO_EN
         dz_r      <= 1'b0;
         div_zero  <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state_r)
            IDLE: begin
               if (start_s) begin
                  dvs_r   <= dvs_mag_s;
                  neg_r_r <= dvd_neg_s;
                  cnt_r   <= CNT_WIDTH'(DATA_WIDTH - 1);
                  stall   <= 1'b1;
`ifdef ADA_DIV_ZERO_EN
                  div_zero <= 1'b0;
                  // Zero divisor: park the dividend magnitude so FIX restores the raw dividend
                  if (divisor == {DATA_WIDTH{1'b0}}) begin
                     dz_r    <= 1'b1;
                     rem_r   <= dvd_mag_s;
                     quo_r   <= {DATA_WIDTH{1'b0}};
                     neg_q_r <= 1'b0;
                     state_r <= FIX;
                  end else begin
                     dz_r    <= 1'b0;
                     rem_r   <= {DATA_WIDTH{1'b0}};
                     quo_r   <= dvd_mag_s;
                     neg_q_r <= dvd_neg_s ^ dvs_neg_s;
                     state_r <= RUN;
                  end
`else
                  rem_r   <= {DATA_WIDTH{1'b0}};
                  quo_r   <= dvd_mag_s;
                  neg_q_r <= dvd_neg_s ^ dvs_neg_s;
                  state_r <= RUN;
`endif
               end else begin
                  state_r <= IDLE;
               end
            end
            RUN: begin
               if (flush) begin
                  state_r <= IDLE;
                  stall   <= 1'b0;
               end else begin
                  // quo_r doubles as the dividend shift register; result bits enter at the bottom
                  quo_r <= {quo_r[DATA_WIDTH-2:0], ~diff_s[DATA_WIDTH]};
                  if (!diff_s[DATA_WIDTH]) begin
                     rem_r <= diff_s[DATA_WIDTH-1:0];
                  end else begin
                     rem_r <= shift_s[DATA_WIDTH-1:0];
                  end
                  cnt_r <= cnt_r - CNT_WIDTH'(1);
                  if (cnt_r == {CNT_WIDTH{1'b0}}) begin
                     state_r <= FIX;
                  end else begin
                     state_r <= RUN;
                  end
               end
            end
            FIX: begin
               state_r <= IDLE;
               stall   <= 1'b0;
               if (!flush) begin
                  quotient  <= neg_q_r ? neg2c(quo_r) : quo_r;
                  remainder <= neg_r_r ? neg2c(rem_r) : rem_r;
                  done      <= 1'b1;
`ifdef ADA_DIV_ZERO_EN
                  div_zero  <= dz_r;
`endif
               end else begin
                  done <= 1'b0;
               end
            end
            default: begin
               state_r <= IDLE;
               stall   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ada_muldiv_div.sv
// Directed, table-driven bench for ada_muldiv_div plus hand sequences for flush and mid-run reset.
// Expected values adapt to the ADA_DIV_ZERO_EN build option.
module tb_ada_muldiv_div;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        op_divs;
   logic        op_divu;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        flush;
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic        stall;
   logic        done;
`ifdef ADA_DIV_ZERO_EN
   logic        div_zero;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [1:0]  op;     // {divs, divu}
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] q;
      logic [31:0] r;
      int          cyc;    // stall-high cycles
      logic        dz;
   } vec_t;

   vec_t vecs[10];

   ada_muldiv_div #(.DATA_WIDTH(32), .CNT_WIDTH(5)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .op_divs   (op_divs),
      .op_divu   (op_divu),
      .dividend  (dividend),
      .divisor   (divisor),
      .flush     (flush),
      .quotient  (quotient),
      .remainder (remainder),
      .stall     (stall),
`ifdef ADA_DIV_ZERO_EN
      .div_zero  (div_zero),
`endif
      .done      (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Starts at a negedge, returns at the negedge where done is seen
   task automatic run_vec(input vec_t v);
      int n;
      logic got;
      op_divs  = v.op[1];
      op_divu  = v.op[0];
      dividend = v.a;
      divisor  = v.b;
      @(negedge clk);
      op_divs = 1'b0;
      op_divu = 1'b0;
      check("start_stall", {31'd0, stall}, 32'd1);
      check("start_done_low", {31'd0, done}, 32'd0);
      n   = 0;
      got = 1'b0;
      for (int i = 0; i < 100 && !got; i++) begin
         if (done) begin
            got = 1'b1;
         end else begin
            if (stall) n++;
            @(negedge clk);
         end
      end
      check("done_seen", {31'd0, got}, 32'd1);
      check("stall_cycles", n, v.cyc);
      check("quotient", quotient, v.q);
      check("remainder", remainder, v.r);
      check("stall_low_at_done", {31'd0, stall}, 32'd0);
`ifdef ADA_DIV_ZERO_EN
      check("div_zero", {31'd0, div_zero}, {31'd0, v.dz});
`endif
   endtask

   initial begin
      int dcount;
      int scount;
      vecs[0] = '{2'b01, 32'd100,        32'd7,          32'd14,         32'd2,          33, 1'b0};
      vecs[1] = '{2'b10, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  32'hFFFF_FFFE,  33, 1'b0};
      vecs[2] = '{2'b10, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          33, 1'b0};
      vecs[3] = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          33, 1'b0};
      vecs[4] = '{2'b01, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          33, 1'b0};
      vecs[5] = '{2'b10, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF,  33, 1'b0};
      vecs[6] = '{2'b11, 32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  32'hFFFF_FFFE,  33, 1'b0};
`ifdef ADA_DIV_ZERO_EN
      vecs[7] = '{2'b01, 32'd5,          32'd0,          32'd0,          32'd5,          1,  1'b1};
      vecs[8] = '{2'b10, 32'hFFFF_FFF8,  32'd0,          32'd0,          32'hFFFF_FFF8,  1,  1'b1};
`else
      vecs[7] = '{2'b01, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          33, 1'b0};
      vecs[8] = '{2'b10, 32'hFFFF_FFF8,  32'd0,          32'd1,          32'hFFFF_FFF8,  33, 1'b0};
`endif
      vecs[9] = '{2'b01, 32'd50,         32'd5,          32'd10,         32'd0,          33, 1'b0};

      rst_n = 1'b0; op_divs = 1'b0; op_divu = 1'b0; flush = 1'b0;
      dividend = 32'd0; divisor = 32'd0;
      #1;
      check("rst_quotient", quotient, 32'd0);
      check("rst_remainder", remainder, 32'd0);
      check("rst_stall", {31'd0, stall}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Back-to-back: each start is issued in the cycle the previous done is high
      for (int i = 0; i < 10; i++) run_vec(vecs[i]);

      // Flush mid-run with an ignored second start
      op_divu = 1'b1; dividend = 32'd9; divisor = 32'd4;
      @(negedge clk);
      op_divu = 1'b0;
      repeat (9) @(negedge clk);
      op_divu = 1'b1; dividend = 32'd100; divisor = 32'd7;
      @(negedge clk);
      op_divu = 1'b0;
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush_stall", {31'd0, stall}, 32'd0);
      check("flush_done", {31'd0, done}, 32'd0);
      check("flush_quotient", quotient, 32'd10);
      check("flush_remainder", remainder, 32'd0);
      dcount = 0; scount = 0;
      for (int i = 0; i < 40; i++) begin
         if (done) dcount++;
         if (stall) scount++;
         @(negedge clk);
      end
      check("flush_no_done", dcount, 32'd0);
      check("flush_no_stall", scount, 32'd0);

      // Flush together with a start in IDLE drops the start
      op_divu = 1'b1; flush = 1'b1; dividend = 32'd9; divisor = 32'd4;
      @(negedge clk);
      op_divu = 1'b0; flush = 1'b0;
      check("flush_start_stall", {31'd0, stall}, 32'd0);

      // Asynchronous reset between edges in the middle of a run
      op_divu = 1'b1; dividend = 32'd100; divisor = 32'd7;
      @(negedge clk);
      op_divu = 1'b0;
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("arst_quotient", quotient, 32'd0);
      check("arst_remainder", remainder, 32'd0);
      check("arst_stall", {31'd0, stall}, 32'd0);
      check("arst_done", {31'd0, done}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_vec('{2'b01, 32'd9, 32'd4, 32'd2, 32'd1, 33, 1'b0});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
